// File: rtl/registro_canales_pkg.sv
// registro_pkg: constants and helpers shared by the multi-channel register bank.
//   WIDTH_DEF / CANALES_DEF : default channel width and channel count
//   sel_t                   : channel-select type sized for the default count
//   slice_offset()          : LSB position of a channel inside the flat bus
package registro_pkg;

    localparam int WIDTH_DEF   = 6;
    localparam int CANALES_DEF = 9;

    typedef logic [$clog2(CANALES_DEF)-1:0] sel_t;

    // Channel idx lives at bits [idx*width +: width] of the flattened bank.
    function automatic int unsigned slice_offset(input int unsigned idx,
                                                 input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/registro_canales_celda.sv
// registro_celda: one storage channel of the register bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of data and occupied flag
//   load       : this channel is the in-range, unclear write target
//   proteger   : write-once qualifier; when high an occupied cell ignores load
//   din        : write data
//   dato       : stored value
//   ocupado    : set by any accepted write, including a write of zero
module registro_celda
    import registro_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             proteger,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dato,
    output logic             ocupado
);

    logic carga_ok;

    assign carga_ok = load && !(proteger && ocupado);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato    <= '0;
            ocupado <= 1'b0;
        end else if (clear) begin
            dato    <= '0;
            ocupado <= 1'b0;
        end else if (carga_ok) begin
            dato    <= din;
            ocupado <= 1'b1;
        end
    end

endmodule

// File: rtl/registro_canales.sv
// registro_canales: CANALES independent WIDTH-bit registers with per-channel
// write, optional write-once protection, synchronous clear and a registered
// read port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous clear of every channel (wins over a write)
//   wr_en/wr_sel/wr_data : write request, channel index, data
//   rd_sel/rd_data  : read index, read data one cycle later (read-first)
//   banco           : all channels flattened, channel i at [i*WIDTH +: WIDTH]
//   ocupado         : per-channel occupied flags
//   lleno           : every channel occupied
//   wr_ack / wr_err : one-cycle accept / reject pulses
module registro_canales
    import registro_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int CANALES    = CANALES_DEF,
    parameter int WRITE_ONCE = 1,
    parameter int SEL_W      = $clog2(CANALES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [SEL_W-1:0]           rd_sel,
    output logic [WIDTH-1:0]           rd_data,
    output logic [CANALES*WIDTH-1:0]   banco,
    output logic [CANALES-1:0]         ocupado,
    output logic                       lleno,
    output logic                       wr_ack,
    output logic                       wr_err
);

    localparam logic PROTEGER = (WRITE_ONCE != 0);

    logic [CANALES-1:0] sel_hit;
    logic               en_rango;
    logic               wr_qual;
    logic               hit_ocupado;
    logic               acepta;
    logic               rechaza;
    logic [WIDTH-1:0]   rd_mux;

    // One-hot decode of the write select; out-of-range values hit nothing.
    generate
        for (genvar gi = 0; gi < CANALES; gi++) begin : g_dec
            assign sel_hit[gi] = ({1'b0, wr_sel} == (SEL_W+1)'(gi));
        end
    endgenerate

    assign en_rango    = |sel_hit;
    assign wr_qual     = wr_en && !clear && en_rango;
    // Occupancy of the target channel without indexing past CANALES.
    assign hit_ocupado = |(sel_hit & ocupado);
    assign acepta      = wr_qual && !(PROTEGER && hit_ocupado);
    // A write that is not cleared away and not accepted is rejected.
    assign rechaza     = wr_en && !clear && !acepta;

    generate
        for (genvar gi = 0; gi < CANALES; gi++) begin : g_celda
            logic [WIDTH-1:0] dato_celda;

            registro_celda #(
                .WIDTH (WIDTH)
            ) u_celda (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .load     (wr_qual && sel_hit[gi]),
                .proteger (PROTEGER),
                .din      (wr_data),
                .dato     (dato_celda),
                .ocupado  (ocupado[gi])
            );

            assign banco[slice_offset(gi, WIDTH) +: WIDTH] = dato_celda;
        end
    endgenerate

    assign lleno = &ocupado;

    // Read mux over the pre-edge bank contents gives read-first behaviour.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CANALES; i++) begin
            if ({1'b0, rd_sel} == (SEL_W+1)'(i)) begin
                rd_mux = banco[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
        end else if (clear) begin
            rd_data <= '0;
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            rd_data <= rd_mux;
            wr_ack  <= acepta;
            wr_err  <= rechaza;
        end
    end

endmodule

// File: tb/tb_registro_canales.sv
module tb_registro_canales;
    import registro_pkg::*;

    localparam int W  = 6;
    localparam int N  = 9;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [W-1:0]  wr_data = '0;
    logic [SW-1:0] rd_sel = '0;

    // Index 0: WRITE_ONCE=1, index 1: WRITE_ONCE=0 (same stimulus).
    logic [W-1:0]   rd_data [2];
    logic [N*W-1:0] banco   [2];
    logic [N-1:0]   ocupado [2];
    logic           lleno   [2];
    logic           wr_ack  [2];
    logic           wr_err  [2];

    registro_canales #(.WIDTH(W), .CANALES(N), .WRITE_ONCE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .rd_sel(rd_sel),
        .rd_data(rd_data[0]), .banco(banco[0]), .ocupado(ocupado[0]),
        .lleno(lleno[0]), .wr_ack(wr_ack[0]), .wr_err(wr_err[0])
    );

    registro_canales #(.WIDTH(W), .CANALES(N), .WRITE_ONCE(0)) dut_ow (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .rd_sel(rd_sel),
        .rd_data(rd_data[1]), .banco(banco[1]), .ocupado(ocupado[1]),
        .lleno(lleno[1]), .wr_ack(wr_ack[1]), .wr_err(wr_err[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain arrays of channel values and occupancy.
    int m_val [2][N];
    bit m_occ [2][N];
    int m_rd  [2];
    bit m_ack [2];
    bit m_err [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_val[d][i] = 0;
                m_occ[d][i] = 0;
            end
            m_rd[d] = 0; m_ack[d] = 0; m_err[d] = 0;
        end
    endtask

    // One rising edge worth of behaviour, using pre-edge state.
    task automatic model_edge();
        int rs, ws;
        rs = int'(rd_sel);
        ws = int'(wr_sel);
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            m_ack[d] = 0; m_err[d] = 0;
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    m_val[d][i] = 0; m_occ[d][i] = 0;
                end
                m_rd[d] = 0;
            end else begin
                m_rd[d] = (rs < N) ? m_val[d][rs] : 0;
                if (wr_en) begin
                    if (ws < N && !(d == 0 && m_occ[d][ws])) begin
                        m_val[d][ws] = int'(wr_data);
                        m_occ[d][ws] = 1;
                        m_ack[d] = 1;
                    end else begin
                        m_err[d] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N*W-1:0] eb;
        logic [N-1:0]   eo;
        bit             el;
        for (int d = 0; d < 2; d++) begin
            eb = '0; eo = '0; el = 1;
            for (int i = 0; i < N; i++) begin
                eb[i*W +: W] = W'(m_val[d][i]);
                eo[i] = m_occ[d][i];
                el = el & m_occ[d][i];
            end
            check($sformatf("%s.banco%0d", tag, d), 64'(banco[d]), 64'(eb));
            check($sformatf("%s.ocupado%0d", tag, d), 64'(ocupado[d]), 64'(eo));
            check($sformatf("%s.rd_data%0d", tag, d), 64'(rd_data[d]), 64'(m_rd[d]));
            check($sformatf("%s.wr_ack%0d", tag, d), 64'(wr_ack[d]), 64'(m_ack[d]));
            check($sformatf("%s.wr_err%0d", tag, d), 64'(wr_err[d]), 64'(m_err[d]));
            check($sformatf("%s.lleno%0d", tag, d), 64'(lleno[d]), 64'(el));
        end
    endtask

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic step(input string tag, input bit c, input bit we,
                        input int ws, input int wd, input int rs);
        clear = c; wr_en = we; wr_sel = SW'(ws); wr_data = W'(wd); rd_sel = SW'(rs);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("%s: clr=%0d we=%0d ws=%0d wd=%02h rs=%0d -> rd=%02h/%02h ack=%0d/%0d err=%0d/%0d occ=%03h/%03h",
                 tag, c, we, ws, wd, rs, rd_data[0], rd_data[1], wr_ack[0], wr_ack[1],
                 wr_err[0], wr_err[1], ocupado[0], ocupado[1]);
    endtask

    initial begin
        model_reset();
        step("reset", 0, 1, 3, 'h2A, 3);
        rst_n = 1'b1;

        // Accept then read.
        step("wr4", 0, 1, 4, 'h15, 0);
        check("wr4.ocupado_lit", 64'(ocupado[0]), 64'h010);
        step("rd4", 0, 0, 0, 0, 4);
        check("rd4.lit", 64'(rd_data[0]), 64'h15);

        // Write-once reject vs overwrite.
        step("wr4_again", 0, 1, 4, 'h3F, 4);
        check("wo.err_lit", 64'(wr_err[0]), 64'h1);
        check("ow.ack_lit", 64'(wr_ack[1]), 64'h1);
        check("ow.ch4_lit", 64'(banco[1][4*W +: W]), 64'h3F);

        // Out of range and zero data.
        step("oor12", 0, 1, 12, 'h11, 12);
        check("oor.err_lit", 64'(wr_err[0]), 64'h1);
        step("wr0_zero", 0, 1, 0, 0, 0);
        check("zero.occ0_lit", 64'(ocupado[0][0]), 64'h1);

        // Reset in the middle of a write request.
        wr_en = 1'b1; wr_sel = 4'd3; wr_data = 6'h2A;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;

        // Fill all channels, then clear with a concurrent write.
        for (int i = 0; i < N; i++) step($sformatf("fill%0d", i), 0, 1, i, i + 1, i);
        check("fill.lleno_lit", 64'(lleno[0]), 64'h1);
        step("clear_wr", 1, 1, 5, 'h22, 5);
        check("clear.lleno_lit", 64'(lleno[0]), 64'h0);

        // Read-during-write returns the old value.
        step("wr2_01", 0, 1, 2, 'h01, 0);
        step("rdw2", 0, 1, 2, 'h07, 2);
        check("rdw.old_lit", 64'(rd_data[1]), 64'h01);
        step("rd2_after", 0, 0, 0, 0, 2);
        check("rdw.new_lit", 64'(rd_data[1]), 64'h07);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            step($sformatf("rnd%0d", k), ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
